// File: rtl/csi_lane_deskew.sv
// CSI-2 lane deskew/merge: measures per-packet lane arrival skew and delays
// early lanes so every enabled lane is presented in one registered word.

module csi_deskew_lane #(
  parameter int DEPTH = 3,
  parameter int SKW_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [7:0]       byte_i,
  input  logic             valid_i,
  input  logic [SKW_W-1:0] dly,
  output logic [7:0]       tap_byte,
  output logic             tap_vld
);
  logic [DEPTH-1:0][7:0] sh;
  logic [DEPTH-1:0]      vsh;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sh  <= '0;
      vsh <= '0;
    end else begin
      sh[0]  <= byte_i;
      vsh[0] <= valid_i;
      for (int j = 1; j < DEPTH; j++) begin
        sh[j]  <= sh[j-1];
        vsh[j] <= vsh[j-1];
      end
    end
  end

  // dly==0 taps the live input; out-of-range delays read as empty
  always_comb begin
    tap_byte = 8'h00;
    tap_vld  = 1'b0;
    if (dly == '0) begin
      tap_byte = byte_i;
      tap_vld  = valid_i;
    end
    for (int j = 1; j <= DEPTH; j++) begin
      if (dly == SKW_W'(j)) begin
        tap_byte = sh[j-1];
        tap_vld  = vsh[j-1];
      end
    end
  end
endmodule

module csi_lane_deskew #(
  parameter int LANES = 4,
  parameter int DEPTH = 3,
  parameter int SKW_W = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [LANES-1:0]   lane_enable_i,
  input  logic [LANES-1:0]   bytes_valid_i,
  input  logic [8*LANES-1:0] byte_i,
  output logic [8*LANES-1:0] lane_byte_o,
  output logic               lane_valid_o,
  output logic [SKW_W-1:0]   skew_o,
  output logic               skew_err_o
);
  localparam int REF_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_STREAM, S_FLUSH} state_t;

  state_t                      state;
  logic [LANES-1:0]            en, arrived, en_cur, act, newl, vtap;
  logic [LANES-1:0][SKW_W-1:0] offset, off_nxt, dly;
  logic [LANES-1:0][7:0]       tap;
  logic [SKW_W-1:0]            cnt, k, maxskew, msk_nxt;
  logic [REF_W-1:0]            ref_q, ref_new, ref_cur;
  logic                        done, all_vt, ref_vld;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    csi_deskew_lane #(.DEPTH(DEPTH), .SKW_W(SKW_W)) u_lane (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .byte_i   (byte_i[8*l +: 8]),
      .valid_i  (bytes_valid_i[l]),
      .dly      (dly[l]),
      .tap_byte (tap[l]),
      .tap_vld  (vtap[l])
    );
  end

  // Offsets/maxskew are looked at one edge early so the word whose ref byte
  // completes alignment is already tapped correctly on that same edge.
  always_comb begin
    en_cur  = (state == S_IDLE) ? lane_enable_i : en;
    act     = bytes_valid_i & en_cur;
    k       = cnt + 1'b1;
    newl    = (state == S_IDLE) ? act : (act & ~arrived);
    done    = (state == S_IDLE) ? (act == en_cur) : ((arrived | newl) == en_cur);
    off_nxt = offset;
    msk_nxt = maxskew;
    ref_new = '0;
    if (state == S_IDLE) begin
      off_nxt = '0;
      msk_nxt = '0;
    end else if (state == S_ALIGN) begin
      for (int l = 0; l < LANES; l++)
        if (newl[l]) off_nxt[l] = k;
      if (done) msk_nxt = k;
    end
    for (int l = LANES-1; l >= 0; l--)
      if (newl[l]) ref_new = REF_W'(l);
    ref_cur = (state == S_STREAM) ? ref_q : ref_new;
    ref_vld = 1'b0;
    for (int l = 0; l < LANES; l++)
      if (ref_cur == REF_W'(l)) ref_vld = bytes_valid_i[l];
    for (int l = 0; l < LANES; l++)
      dly[l] = msk_nxt - off_nxt[l];
    all_vt = &(vtap | ~en_cur);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= S_IDLE;
      en           <= '0;
      arrived      <= '0;
      offset       <= '0;
      cnt          <= '0;
      maxskew      <= '0;
      ref_q        <= '0;
      lane_byte_o  <= '0;
      lane_valid_o <= 1'b0;
      skew_o       <= '0;
      skew_err_o   <= 1'b0;
    end else begin
      skew_err_o <= 1'b0;
      for (int l = 0; l < LANES; l++)
        lane_byte_o[8*l +: 8] <= en_cur[l] ? tap[l] : 8'h00;
      case (state)
        S_IDLE: begin
          en           <= lane_enable_i;
          lane_valid_o <= 1'b0;
          if (act != '0) begin
            cnt     <= '0;
            offset  <= off_nxt;
            arrived <= act;
            if (done) begin
              maxskew      <= '0;
              skew_o       <= '0;
              ref_q        <= ref_new;
              lane_valid_o <= 1'b1;
              state        <= S_STREAM;
            end else begin
              state <= S_ALIGN;
            end
          end
        end
        S_ALIGN: begin
          cnt          <= k;
          offset       <= off_nxt;
          arrived      <= arrived | newl;
          lane_valid_o <= 1'b0;
          if (done) begin
            maxskew      <= k;
            skew_o       <= k;
            ref_q        <= ref_new;
            lane_valid_o <= 1'b1;
            state        <= S_STREAM;
          end else if (k == SKW_W'(DEPTH)) begin
            skew_err_o <= 1'b1;
            state      <= S_FLUSH;
          end
        end
        S_STREAM: begin
          // an early lane whose delayed valid already dropped is a mismatch too
          if (ref_vld && all_vt) begin
            lane_valid_o <= 1'b1;
          end else begin
            lane_valid_o <= 1'b0;
            if (ref_vld || act != '0) begin
              skew_err_o <= 1'b1;
              state      <= S_FLUSH;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          lane_valid_o <= 1'b0;
          if (act == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
